// File: rtl/otprom_array.sv
// One-time-programmable PROM cell array: registered reads plus a multi-cycle, OR-only burn engine with a lock word.
// Optional burn commit counter output enabled by defining OTPROM_BURN_CNT_EN.
module otprom_array #(
  parameter int BUS_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 6,
  parameter int BURN_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_WIDTH-1:0]      ram_raddr,
  input  logic                      ram_ren,
  output logic [DATA_WIDTH-1:0]     ram_rdata,
  input  logic [BUS_WIDTH-1:0]      ram_waddr,
  input  logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH/8-1:0]   ram_wen,
  output logic                      burn_busy,
  output logic                      burn_err
`ifdef OTPROM_BURN_CNT_EN
  ,
  output logic [7:0]                burn_cnt
`endif
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CW     = $clog2(BURN_CYCLES);

  typedef enum logic {IDLE, BURN} state_t;

  // Non-volatile cells: erased at power-up and deliberately untouched by reset.
  logic [DATA_WIDTH-1:0] cells_q [DEPTH] = '{default: '0};

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DEPTH_LOG2-1:0] ridx, widx;
  logic                  r_oor, w_oor, lock, req, commit;
  logic [DATA_WIDTH-1:0] wmask;
  logic                  unused_addr_lsbs;

  assign ridx   = ram_raddr[DEPTH_LOG2+1:2];
  assign widx   = ram_waddr[DEPTH_LOG2+1:2];
  assign r_oor  = |ram_raddr[BUS_WIDTH-1:DEPTH_LOG2+2];
  assign w_oor  = |ram_waddr[BUS_WIDTH-1:DEPTH_LOG2+2];
  assign lock   = cells_q[DEPTH-1][0];
  assign req    = |ram_wen;
  assign commit = (state_q == BURN) && (cnt_q == '0);
  assign unused_addr_lsbs = ^{ram_raddr[1:0], ram_waddr[1:0]};

  always_comb begin
    wmask = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (ram_wen[b]) wmask[8*b +: 8] = ram_wdata[8*b +: 8];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (ram_ren) rdata_d = r_oor ? '0 : cells_q[ridx];

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!w_oor && !lock) begin
            state_d = BURN;
            cnt_d   = CW'(BURN_CYCLES - 1);
            idx_d   = widx;
            mask_d  = wmask;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BURN: begin
        // Any request arriving mid-burn, commit cycle included, is dropped.
        if (req) err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit) cells_q[idx_q] <= cells_q[idx_q] | mask_q;
  end

  assign ram_rdata = rdata_q;
  assign burn_busy = busy_q;
  assign burn_err  = err_q;

`ifdef OTPROM_BURN_CNT_EN
  logic [7:0] burn_cnt_q, burn_cnt_d;

  always_comb begin
    burn_cnt_d = burn_cnt_q;
    if (commit && burn_cnt_q != 8'hFF) burn_cnt_d = burn_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) burn_cnt_q <= '0;
    else       burn_cnt_q <= burn_cnt_d;
  end

  assign burn_cnt = burn_cnt_q;
`endif

endmodule

// File: tb/tb_otprom_array.sv
// Self-checking bench for otprom_array: directed test-plan scenarios plus randomized traffic
// compared every cycle against a cycle-count-based behavioural model of the PROM.
module tb_otprom_array;

  localparam int DEPTH = 64;
  localparam int BC    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ram_raddr;
  logic        ram_ren;
  logic [31:0] ram_rdata;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wen;
  logic        burn_busy;
  logic        burn_err;
`ifdef OTPROM_BURN_CNT_EN
  logic [7:0]  burn_cnt;
`endif

  otprom_array dut (
    .clk       (clk),
    .reset     (reset),
    .ram_raddr (ram_raddr),
    .ram_ren   (ram_ren),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .burn_busy (burn_busy),
    .burn_err  (burn_err)
`ifdef OTPROM_BURN_CNT_EN
    ,
    .burn_cnt  (burn_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Behavioural model: a burn is just "commit mask to word after BC more edges".
  logic [31:0] m_mem [DEPTH];
  int          m_left = 0;
  int          m_idx = 0;
  logic [31:0] m_mask = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  int          m_cnt = 0;
  bit          checking = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  end

  always @(posedge clk) begin : model
    logic [31:0] nr;
    if (reset) begin
      m_rdata  = '0;
      m_left   = 0;
      m_err    = 1'b0;
      m_cnt    = 0;
      checking = 1'b1;
    end else begin
      nr = m_rdata;
      if (ram_ren) nr = (ram_raddr >= 32'(DEPTH * 4)) ? 32'h0 : m_mem[int'(ram_raddr >> 2)];
      if (m_left > 0) begin
        if (ram_wen != 0) m_err = 1'b1;
        m_left--;
        if (m_left == 0) begin
          m_mem[m_idx] = m_mem[m_idx] | m_mask;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (ram_wen != 0) begin
        if (ram_waddr >= 32'(DEPTH * 4) || m_mem[DEPTH-1][0]) begin
          m_err = 1'b1;
        end else begin
          m_left = BC;
          m_idx  = int'(ram_waddr >> 2);
          m_mask = '0;
          for (int b = 0; b < 4; b++)
            if (ram_wen[b]) m_mask[8*b +: 8] = ram_wdata[8*b +: 8];
        end
      end
      m_rdata = nr;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cyc_rdata", ram_rdata, m_rdata);
      checkOutput("cyc_busy", {31'b0, burn_busy}, {31'b0, (m_left > 0)});
      checkOutput("cyc_err", {31'b0, burn_err}, {31'b0, m_err});
`ifdef OTPROM_BURN_CNT_EN
      checkOutput("cyc_cnt", {24'b0, burn_cnt}, 32'(m_cnt));
`endif
    end
  end

  task automatic applyStimulus(input logic rst, input logic ren, input logic [31:0] ra,
                               input logic [3:0] wen, input logic [31:0] wa, input logic [31:0] wd);
    reset     = rst;
    ram_ren   = ren;
    ram_raddr = ra;
    ram_wen   = wen;
    ram_waddr = wa;
    ram_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic readWord(input logic [31:0] a);
    applyStimulus(1'b0, 1'b1, a, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic burnWord(input logic [31:0] a, input logic [31:0] d, input logic [3:0] wen);
    applyStimulus(1'b0, 1'b0, 32'h0, wen, a, d);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 30 && burn_busy; i++) idle();
    checkOutput("wait_idle_timeout", {31'b0, burn_busy}, 32'h0);
  endtask

  initial begin
    int n;
    logic [31:0] wa, wd;
    logic [3:0]  we;
    applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    idle();

    // Plan 1: fresh array reads zero, flags clear.
    readWord(32'h10);
    checkOutput("tp1_rdata", ram_rdata, 32'h0);
    checkOutput("tp1_busy", {31'b0, burn_busy}, 32'h0);
    checkOutput("tp1_err", {31'b0, burn_err}, 32'h0);

    // Plan 2: busy exactly BC cycles, new value visible afterwards.
    burnWord(32'h10, 32'h1, 4'hF);
    n = 0;
    while (burn_busy && n < 20) begin
      n++;
      idle();
    end
    checkOutput("tp2_busy_len", 32'(n), 32'd8);
    readWord(32'h10);
    checkOutput("tp2_rdata", ram_rdata, 32'h1);
    checkOutput("tp2_model", m_mem[4], 32'h1);
`ifdef OTPROM_BURN_CNT_EN
    checkOutput("tp2_cnt", {24'b0, burn_cnt}, 32'd1);
`endif

    // Plan 3: OR accumulation with byte enables; zero burn is a no-op.
    burnWord(32'h14, 32'hF0, 4'hF);
    waitIdle();
    burnWord(32'h14, 32'h00FF0F0F, 4'b0001);
    waitIdle();
    readWord(32'h14);
    checkOutput("tp3_rdata_or", ram_rdata, 32'h000000FF);
    burnWord(32'h14, 32'h0, 4'hF);
    waitIdle();
    readWord(32'h14);
    checkOutput("tp3_rdata_zero", ram_rdata, 32'h000000FF);

    // Plan 4: request in busy cycle 3 is dropped; out-of-range rejected.
    burnWord(32'h24, 32'h3C, 4'hF);
    idle();
    burnWord(32'h28, 32'h77, 4'hF);
    checkOutput("tp4_err_busy", {31'b0, burn_err}, 32'h1);
    waitIdle();
    readWord(32'h24);
    checkOutput("tp4_first_commit", ram_rdata, 32'h3C);
    readWord(32'h28);
    checkOutput("tp4_dropped", ram_rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    idle();
    burnWord(32'h100, 32'h1, 4'hF);
    checkOutput("tp4_oor_err", {31'b0, burn_err}, 32'h1);
    checkOutput("tp4_oor_busy", {31'b0, burn_busy}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    idle();

    // Plan 6: reset mid-burn aborts without commit, cells survive reset.
    burnWord(32'h20, 32'hFF, 4'hF);
    idle();
    applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    checkOutput("tp6_busy_after_reset", {31'b0, burn_busy}, 32'h0);
    idle();
    readWord(32'h20);
    checkOutput("tp6_aborted", ram_rdata, 32'h0);
    readWord(32'h10);
    checkOutput("tp6_retained", ram_rdata, 32'h1);

    // Random traffic; word 6 is left untouched and the lock bit is never burned here.
    for (int i = 0; i < 400; i++) begin
      wa = 32'($urandom_range(0, 70)) * 4;
      if (wa == 32'h18) wa = 32'h1C;
      wd = $urandom;
      if (wa == 32'hFC) wd[0] = 1'b0;
      we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 300)), we, wa, wd);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    idle();

    // Plan 5: lock word blocks all later burns.
    burnWord(32'hFC, 32'h1, 4'hF);
    waitIdle();
    readWord(32'hFC);
    checkOutput("tp5_lock_bit", {31'b0, ram_rdata[0]}, 32'h1);
    burnWord(32'h18, 32'hA5, 4'hF);
    checkOutput("tp5_locked_err", {31'b0, burn_err}, 32'h1);
    checkOutput("tp5_locked_busy", {31'b0, burn_busy}, 32'h0);
    readWord(32'h18);
    checkOutput("tp5_locked_rdata", ram_rdata, 32'h0);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otprom_array.md
Name: otprom_array

Overview:
Behavioural model of the one-time-programmable PROM cell array. It sits directly downstream of the secure-boot agent and is driven by the agent's s_ram_* bus.
- Reads are registered with 1-cycle latency, matching the agent's boot-time fetch of address 0x10.
- Writes are burns: cells can only go 0 to 1, and each burn takes a multi-cycle program time.
- A lock bit in the last word permanently blocks further burns.

Parameters:
BUS_WIDTH, 32, address width (matches `BUS_WIDTH).
DATA_WIDTH, 32, data width (matches `DATA_WIDTH); must be a multiple of 8.
DEPTH_LOG2, 6, log2 of word count (64 words).
BURN_CYCLES, 8, clock cycles a burn occupies; must be at least 2.

Ports:
clk  in  1  clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
ram_raddr  in  BUS_WIDTH  byte read address.
ram_ren  in  1  read enable.
ram_rdata  out  DATA_WIDTH  registered read data.
ram_waddr  in  BUS_WIDTH  byte burn address.
ram_wdata  in  DATA_WIDTH  burn data; 1 bits are burned.
ram_wen  in  DATA_WIDTH/8  byte enables; a non-zero value requests a burn.
burn_busy  out  1  high while a burn is in progress.
burn_err  out  1  sticky error flag.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Cell array:
  - DEPTH = 2^DEPTH_LOG2 words.
  - All cells are 0 at time zero.
  - The cells are NOT affected by reset (non-volatile).
- Address decode:
  - Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] is ignored.
  - An address is out of range if any bit at or above DEPTH_LOG2+2 is set.
- Read path:
  - If ram_ren=1 in cycle N, ram_rdata = cell[idx] in cycle N+1.
  - An out-of-range read returns 0.
  - If ram_ren=0, ram_rdata holds its previous value.
  - Reset sets ram_rdata to 0.
  - Reads are independent of burns. A read of a word under burn returns its old value until the commit cycle. A read issued in the commit cycle returns the old value; a read issued in the cycle after commit returns the new value.
- Lock: lock = cell[DEPTH-1][0].
- Burn FSM, two states, IDLE and BURN:
  - Reset state is IDLE, with burn_busy=0 and burn_err=0.
  - A request is a cycle with ram_wen != 0.
- Request in IDLE:
  - Accepted only if the address is in range and lock=0.
  - On accept: latch idx, mask (wdata AND byte-enable expansion) and counter=BURN_CYCLES-1, then go to BURN.
  - burn_busy rises in the next cycle.
  - If rejected: no state change, and burn_err is set in the next cycle.
- BURN state:
  - The counter decrements each cycle.
  - When counter==0 (commit cycle), cell[idx] <= cell[idx] OR mask at the clock edge, and the FSM returns to IDLE. burn_busy falls in the following cycle.
  - Total burn_busy high time is exactly BURN_CYCLES cycles.
- Request while in BURN, including the commit cycle: the request is dropped and burn_err is set.
- Burn semantics: a 0 in the mask leaves the cell unchanged; bits are never cleared.
- Burning the lock word: accepted if lock=0. Once it commits with bit 0 set, every later request is rejected.
- burn_err stays set until reset.
- Reset during BURN:
  - The FSM returns to IDLE with no commit; the target word is unchanged.
  - burn_busy=0 in the cycle after reset.

Optional Feature:
OTPROM_BURN_CNT_EN
- Defined: adds output burn_cnt [7:0].
  - burn_cnt increments by 1 on each commit and saturates at 255.
  - Reset sets burn_cnt to 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
1. Deassert reset, then read 0x10 -> rdata=0x00000000 one cycle later; burn_busy=0; burn_err=0.
2. Burn 0x10, wdata=0x1, wen=4'hF -> burn_busy high exactly 8 cycles; a read of 0x10 issued after burn_busy falls returns 0x00000001.
3. Burn 0x14, wdata=0xF0, wen=4'hF, then burn 0x14, wdata=0xFF0F0F, wen=4'b0001 -> read 0x14 returns 0x000000FF. Then burn 0x14, wdata=0x0 -> still 0x000000FF.
4. Burn request during the 3rd busy cycle -> request dropped, burn_err=1 next cycle, first burn still commits. Out-of-range address 0x100 -> rejected, burn_err=1.
5. Burn 0xFC, wdata=0x1 -> lock set. A later burn of 0x18, wdata=0xA5 -> rejected, burn_err=1, 0x18 reads 0.
6. Assert reset in busy cycle 3 of a burn to 0x20, wdata=0xFF -> burn_busy=0 the next cycle, 0x20 reads 0, and the earlier 0x10=0x1 is retained across reset.
